// File: rtl/feeder_pkg.sv
// Shared types for the input feeder and the layer controller.
package feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Circular operand buffer: storage, wrapping pointers and occupancy count.
module feeder_fifo
  import feeder_pkg::*;
#(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [BITWIDTH-1:0]   i_push_data,
  input  logic                  i_pop,
  output logic [BITWIDTH-1:0]   o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                  o_wr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BITWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_push_ok;

  // No write-through at full, even when a pop happens in the same cycle.
  assign o_wr_ready = (r_count < FULL);
  assign w_push_ok  = i_push && o_wr_ready;
  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/input_feeder.sv
// Streams a controller-specified burst of buffered operands to the compute lanes
// through a registered valid/ready output stage.
module input_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic signed [BITWIDTH-1:0]  i_wr_data,
  input  logic                        i_start,
  input  logic [LEN_W-1:0]            i_len,
  output logic                        o_busy,
  output logic signed [BITWIDTH-1:0]  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_done,
  output logic [$clog2(DEPTH):0]      o_count
);

  state_e                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_accepted;
  logic [BITWIDTH-1:0]   r_data;
  logic                  r_valid;
  logic                  r_done;

  logic [BITWIDTH-1:0]   w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_pop;
  logic                  w_xfer;
  logic [LEN_W-1:0]      w_acc_next;

  feeder_fifo #(
    .BITWIDTH (BITWIDTH),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (i_wr_valid),
    .i_push_data (i_wr_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_wr_ready  (o_wr_ready)
  );

  assign w_xfer     = r_valid && i_ready;
  assign w_pop      = (r_state == ST_STREAM) && (r_issued < r_len) && (w_count != '0) &&
                      (!r_valid || i_ready);
  assign w_acc_next = w_xfer ? r_accepted + 1'b1 : r_accepted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_xfer) r_accepted <= r_accepted + 1'b1;
      if (w_pop) begin
        r_data   <= w_head;
        r_valid  <= 1'b1;
        r_issued <= r_issued + 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_STREAM;
            r_len      <= i_len;
            r_issued   <= '0;
            r_accepted <= '0;
          end
        end
        ST_STREAM: begin
          // A zero-length burst falls straight through on the first STREAM cycle.
          if (w_acc_next == r_len) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_done  = r_done;
  assign o_count = w_count;

endmodule
